fb_kbd_term: RTL and testbench
==============================

# fb_kbd_term

Memory-mapped keyboard/terminal peripheral that answers the external-device half of the data-memory address space (address bit 10 set). It buffers keyboard bytes in a receive FIFO, drives a terminal output byte with a valid/ready handshake, and exposes status, data (terminal out) and keyboard (FIFO pop) registers to the load/store path. It sits beside data memory and is selected by the same address decode the MMU applies: offset 0 is status, 1 is data, 2 is keyboard.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: receive FIFO entries; must be a power of two, 2..64.

Ports:
- `clk` — in, 1: the single clock.
- `rst_n` — in, 1: reset, synchronous, active-low.
- `io_sel` — in, 1: device access this cycle (address bit 10).
- `io_reg` — in, 2: register offset (address bits 1:0).
- `io_re` — in, 1: read strobe, qualified by `io_sel`.
- `io_we` — in, 1: write strobe, qualified by `io_sel`.
- `io_wdata` — in, 32: write data.
- `io_rdata` — out, 32: read data, registered.
- `kb_valid` — in, 1: keyboard byte present, single-cycle pulse per byte.
- `kb_data` — in, 8: keyboard byte.
- `term_valid` — out, 1: terminal byte pending.
- `term_data` — out, 8: terminal byte.
- `term_ready` — in, 1: terminal accepts byte.

## Operation

Register map (offset = `io_reg`):
- 0 STATUS
  - Read: bit0 rx_nonempty; bit1 rx_full; bit2 tx_busy (= `term_valid`); bit3 overflow (sticky); bits[14:8] rx count; all other bits 0.
  - Write: bit3 = 1 clears overflow; all other bits ignored.
- 1 DATA
  - Write while tx idle: loads `io_wdata[7:0]` into `term_data` and sets `term_valid`.
  - Write while tx busy: dropped; no state change.
  - Read: returns `{24'b0, term_data}`.
- 2 KBD
  - Read while nonempty: returns `{24'b0, head byte}` and pops the FIFO.
  - Read while empty: returns 0 and does not pop.
  - Write: ignored.
- 3: reserved; reads return 0, writes are ignored.

Strobes are ignored unless `io_sel` = 1. `io_re` and `io_we` asserted together to the same register: the write takes effect and read data reflects the pre-write state.

Receive FIFO (circular buffer):
- Pointers wrap modulo `FIFO_DEPTH`.
- Count is `$clog2(FIFO_DEPTH)+1` bits wide.
- `kb_valid` while not full: push.
- `kb_valid` while full, with no pop in the same cycle: byte dropped, overflow set.
- Push and pop in the same cycle: both occur and count is unchanged. This holds when full (no overflow) and when empty: the pop sees empty, so read returns 0 and only the push takes effect.
- Overflow set and a W1C clear in the same cycle: set wins.

Transmit states:
- IDLE → BUSY on an accepted DATA write.
- BUSY → IDLE on `term_valid && term_ready`.
- `term_data` is stable while BUSY.
- A DATA write in the same cycle as the completing handshake is dropped, because busy is evaluated before the handshake.

## Timing

Reset (`rst_n` low at a clock edge):
- `io_rdata` = 0, `term_valid` = 0, `term_data` = 0.
- FIFO empty, overflow = 0.
- Reset mid-transfer discards pending tx and all FIFO contents.

Latency:
- Read: `io_rdata` is valid on the cycle after `io_re`. It holds its value until the next read and is not cleared between reads.
- Keyboard byte pushed at edge N: visible in STATUS on a read issued in cycle N+1.
- DATA write at edge N: `term_valid` = 1 from cycle N+1.
- Handshake completing at edge M: `term_valid` = 0 from cycle M+1.
- Back-to-back KBD reads pop one entry per cycle.

## Configuration

`FB_KBD_ECHO_EN`:
- Defined: each pushed keyboard byte is also loaded into the transmitter, but only if tx is IDLE and no accepted DATA write occurs that cycle. A CPU write has priority; a blocked echo is silently skipped and does not set overflow.
- Undefined: the terminal carries only CPU-written bytes.

## Test plan

- Reset: hold `rst_n` = 0 for 2 cycles, then read STATUS → `io_rdata` = 0x0000_0000, `term_valid` = 0.
- FIFO order: push 0x41, 0x42, 0x43; read KBD three times → 0x41, 0x42, 0x43. STATUS read between pushes and pops shows count 3→0; a fourth KBD read returns 0.
- Overflow (`FIFO_DEPTH` = 8): push 9 bytes → STATUS = 0x0000_080B. Write STATUS 0x8 → STATUS = 0x0000_0803. The ninth byte is never returned.
- Full push+pop: with the FIFO full, assert `kb_valid` (0x55) with a KBD read in the same cycle → count stays 8, overflow stays 0, and 0x55 is returned by the eighth subsequent read.
- Tx handshake:
  - Write DATA 0x7A with `term_ready` = 0 → `term_valid` = 1, `term_data` = 0x7A.
  - A second DATA write of 0x7B is dropped.
  - Assert `term_ready` for one cycle → `term_valid` = 0 on the next cycle.
- Echo (macro defined): push 0x31 with tx idle → `term_data` = 0x31, `term_valid` = 1. Also read KBD → 0x31.

Source files
------------

// File: rtl/fb_kbd_term.sv
// Keyboard/terminal MMIO peripheral: receive FIFO for keyboard bytes, handshaked terminal output.
// Optional FB_KBD_ECHO_EN: echo each pushed keyboard byte to the terminal when tx is idle.
module fb_kbd_term #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_sel,
    input  logic [1:0]  io_reg,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        term_valid,
    output logic [7:0]  term_data,
    input  logic        term_ready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StBusy} tx_state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    tx_state_e     tx_state_q;
    logic          term_valid_q;
    logic [7:0]    term_data_q;
    logic [31:0]   rdata_q, rdata_d;

    logic          acc_re, acc_we;
    logic          rx_empty, rx_full;
    logic          pop, push, ovf_set, ovf_clr;
    logic          data_wr, echo_ld;
    logic [6:0]    cnt7;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = ^io_wdata[31:8];

    always_comb begin
        acc_re   = io_sel & io_re;
        acc_we   = io_sel & io_we;
        rx_empty = (count_q == '0);
        rx_full  = (count_q == CW'(FIFO_DEPTH));
        pop      = acc_re && (io_reg == 2'd2) && !rx_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push     = kb_valid && (!rx_full || pop);
        ovf_set  = kb_valid && rx_full && !pop;
        ovf_clr  = acc_we && (io_reg == 2'd0) && io_wdata[3];
        data_wr  = acc_we && (io_reg == 2'd1) && (tx_state_q == StIdle);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        cnt7   = 7'(count_q);
        status = {17'b0, cnt7, 4'b0, ovf_q, term_valid_q, rx_full, !rx_empty};

        rdata_d = rdata_q;
        if (acc_re) begin
            case (io_reg)
                2'd0:    rdata_d = status;
                2'd1:    rdata_d = {24'b0, term_data_q};
                2'd2:    rdata_d = rx_empty ? 32'b0 : {24'b0, mem_q[rd_ptr_q]};
                default: rdata_d = 32'b0;
            endcase
        end
    end

`ifdef FB_KBD_ECHO_EN
    assign echo_ld = push && (tx_state_q == StIdle) && !data_wr;
`else
    assign echo_ld = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= 32'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_set | (ovf_q & ~ovf_clr);
            rdata_q <= rdata_d;
        end
    end

    // Busy is judged before the handshake, so a write on the completing cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q   <= StIdle;
            term_valid_q <= 1'b0;
            term_data_q  <= 8'h00;
        end else begin
            case (tx_state_q)
                StIdle: begin
                    if (data_wr) begin
                        term_data_q  <= io_wdata[7:0];
                        term_valid_q <= 1'b1;
                        tx_state_q   <= StBusy;
                    end else if (echo_ld) begin
                        term_data_q  <= kb_data;
                        term_valid_q <= 1'b1;
                        tx_state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (term_ready) begin
                        term_valid_q <= 1'b0;
                        tx_state_q   <= StIdle;
                    end
                end
                default: begin
                    term_valid_q <= 1'b0;
                    tx_state_q   <= StIdle;
                end
            endcase
        end
    end

    assign io_rdata   = rdata_q;
    assign term_valid = term_valid_q;
    assign term_data  = term_data_q;
endmodule

// File: tb/tb_fb_kbd_term.sv
// Scoreboard bench for fb_kbd_term: stimulus queues expected reads/terminal states, monitor compares.
module tb_fb_kbd_term;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_sel = 1'b0;
    logic [1:0]  io_reg = 2'd0;
    logic        io_re = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_wdata = 32'b0;
    logic [31:0] io_rdata;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        term_valid;
    logic [7:0]  term_data;
    logic        term_ready = 1'b0;

    logic        chk_term = 1'b0;
    logic        re_fire = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] rq_val[$];
    string       rq_name[$];
    logic [8:0]  tq_val[$];
    string       tq_name[$];

    fb_kbd_term #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .io_sel(io_sel), .io_reg(io_reg), .io_re(io_re),
        .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata), .kb_valid(kb_valid),
        .kb_data(kb_data), .term_valid(term_valid), .term_data(term_data),
        .term_ready(term_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) re_fire <= rst_n && io_sel && io_re;

    // Monitor: read data appears the cycle after the strobe; terminal checks on request.
    always @(negedge clk) begin
        if (re_fire) begin
            n_cmp++;
            if (rq_val.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: got %h, no expected value queued", io_rdata);
            end else begin
                automatic logic [31:0] e = rq_val.pop_front();
                automatic string nm = rq_name.pop_front();
                if (io_rdata !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", nm, io_rdata, e);
                end
            end
        end
        if (chk_term) begin
            n_cmp++;
            if (tq_val.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_term_check: got %b/%h", term_valid, term_data);
            end else begin
                automatic logic [8:0] e = tq_val.pop_front();
                automatic string nm = tq_name.pop_front();
                if ({term_valid, term_data} !== e) begin
                    n_bad++;
                    $display("FAIL %s: got valid=%b data=%h expected valid=%b data=%h",
                             nm, term_valid, term_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic step(input logic re, input logic we, input logic [1:0] rg,
                        input logic [31:0] wd, input logic kv, input logic [7:0] kd,
                        input logic rdy);
        @(posedge clk);
        #1;
        io_sel     = re | we;
        io_re      = re;
        io_we      = we;
        io_reg     = rg;
        io_wdata   = wd;
        kb_valid   = kv;
        kb_data    = kd;
        term_ready = rdy;
        chk_term   = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [1:0] rg, input logic [31:0] exp, input string nm);
        rq_val.push_back(exp);
        rq_name.push_back(nm);
        step(1'b1, 1'b0, rg, 32'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [1:0] rg, input logic [31:0] d);
        step(1'b0, 1'b1, rg, d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic kb(input logic [7:0] d);
        step(1'b0, 1'b0, 2'd0, 32'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pulse_ready();
        step(1'b0, 1'b0, 2'd0, 32'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_t(input logic v, input logic [7:0] d, input string nm);
        tq_val.push_back({v, d});
        tq_name.push_back(nm);
        idle();
        chk_term = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges.
        idle();
        idle();
        rst_n = 1'b1;
        rd(2'd0, 32'h0000_0000, "reset_status");
        chk_t(1'b0, 8'h00, "reset_term");

        // FIFO ordering and count.
        kb(8'h41);
        kb(8'h42);
        kb(8'h43);
        rd(2'd0, 32'h0000_0301, "status_cnt3");
        rd(2'd2, 32'h41, "kbd_0x41");
        rd(2'd0, 32'h0000_0201, "status_cnt2");
        rd(2'd2, 32'h42, "kbd_0x42");
        rd(2'd2, 32'h43, "kbd_0x43");
        rd(2'd0, 32'h0000_0000, "status_cnt0");
        rd(2'd2, 32'h0, "kbd_empty");

        // Overflow and W1C clear.
        for (int i = 0; i < 9; i++) kb(8'(8'h60 + i));
        rd(2'd0, 32'h0000_080B, "status_overflow");
        wr(2'd0, 32'h0000_0008);
        rd(2'd0, 32'h0000_0803, "status_ovf_cleared");
        for (int i = 0; i < 8; i++) rd(2'd2, 32'(32'h60 + i), "kbd_ovf_drain");
        rd(2'd2, 32'h0, "kbd_ninth_dropped");
        rd(2'd3, 32'h0, "reserved_reg");

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) kb(8'(8'h70 + i));
        rq_val.push_back(32'h70);
        rq_name.push_back("kbd_full_pushpop");
        step(1'b1, 1'b0, 2'd2, 32'b0, 1'b1, 8'h55, 1'b0);
        rd(2'd0, 32'h0000_0803, "status_full_pushpop");
        for (int i = 1; i < 8; i++) rd(2'd2, 32'(32'h70 + i), "kbd_full_drain");
        rd(2'd2, 32'h55, "kbd_0x55_eighth");

        // Push and pop together while empty: only the push lands.
        rq_val.push_back(32'h0);
        rq_name.push_back("kbd_empty_pushpop");
        step(1'b1, 1'b0, 2'd2, 32'b0, 1'b1, 8'h99, 1'b0);
        rd(2'd0, 32'h0000_0101, "status_empty_pushpop");
        rd(2'd2, 32'h99, "kbd_0x99");

        // Transmit handshake.
        pulse_ready();
        idle();
        wr(2'd1, 32'h7A);
        chk_t(1'b1, 8'h7A, "tx_loaded");
        rd(2'd1, 32'h7A, "data_readback");
        rd(2'd0, 32'h0000_0004, "status_tx_busy");
        wr(2'd1, 32'h7B);
        chk_t(1'b1, 8'h7A, "tx_busy_write_dropped");
        pulse_ready();
        chk_t(1'b0, 8'h7A, "tx_handshake_done");
        rd(2'd0, 32'h0000_0000, "status_tx_idle");

        // Write on the completing handshake cycle is dropped.
        wr(2'd1, 32'h11);
        chk_t(1'b1, 8'h11, "tx_loaded_0x11");
        step(1'b0, 1'b1, 2'd1, 32'h22, 1'b0, 8'h00, 1'b1);
        chk_t(1'b0, 8'h11, "tx_write_on_handshake_dropped");

        // Reset mid-transfer.
        kb(8'h5A);
        wr(2'd1, 32'h33);
        idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        rd(2'd0, 32'h0000_0000, "status_after_midreset");
        chk_t(1'b0, 8'h00, "term_after_midreset");

        // Read and write DATA together: read sees pre-write byte.
        rq_val.push_back(32'h0);
        rq_name.push_back("data_rw_same_cycle");
        step(1'b1, 1'b1, 2'd1, 32'h44, 1'b0, 8'h00, 1'b0);
        chk_t(1'b1, 8'h44, "tx_loaded_0x44");
        pulse_ready();
        chk_t(1'b0, 8'h44, "tx_idle_0x44");

        // Keyboard echo behaviour.
        kb(8'h31);
`ifdef FB_KBD_ECHO_EN
        chk_t(1'b1, 8'h31, "echo_loaded");
        pulse_ready();
`else
        chk_t(1'b0, 8'h44, "no_echo");
`endif
        rd(2'd2, 32'h31, "kbd_0x31");

        repeat (4) idle();
        n_cmp++;
        if (rq_val.size() != 0 || tq_val.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expectations: got %0d read / %0d term left, expected 0 / 0",
                     rq_val.size(), tq_val.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
